// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// fetch_if: hazard, redirect, instruction-memory and IF/ID signals of the fetch stage.
interface fetch_if;

    logic        Stall_IF;
    logic        Stall_ID;
    logic        PCSrc_ID;
    logic [31:0] PCBranch_ID;
    logic        Jump_ID;
    logic [31:0] PCJump_ID;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] Instr_ID;
    logic [31:0] PCPlus4_ID;
    logic        Valid_ID;

    modport master (
        input  Stall_IF, Stall_ID, PCSrc_ID, PCBranch_ID, Jump_ID, PCJump_ID,
        input  imem_ready, imem_rdata,
        output imem_req, imem_addr, Instr_ID, PCPlus4_ID, Valid_ID
    );

    modport slave (
        output Stall_IF, Stall_ID, PCSrc_ID, PCBranch_ID, Jump_ID, PCJump_ID,
        output imem_ready, imem_rdata,
        input  imem_req, imem_addr, Instr_ID, PCPlus4_ID, Valid_ID
    );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with enable and synchronous bubble clear.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus4,
    output logic        o_valid
);

    // A bubble clears the instruction and valid flag but keeps the last PC+4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_instr   <= NOP_INSTR;
            o_pcplus4 <= '0;
            o_valid   <= 1'b0;
        end else if (i_en) begin
            o_instr <= i_clr ? NOP_INSTR : i_instr;
            o_valid <= ~i_clr;
            if (!i_clr)
                o_pcplus4 <= i_pcplus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with stall hold buffer and
// wrong-path response dropping; no branch delay slot.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    fetch_if.master  bus
);

    fetch_state_t r_state, w_state_nx;
    logic [31:0]  r_pc, w_pc_nx;
    logic [31:0]  r_req_addr, w_req_addr_nx;
    logic [31:0]  r_hold, w_hold_nx;
    logic         w_stall;
    logic         w_redirect;
    logic [31:0]  w_target;
    logic [31:0]  w_pc_plus4;
    logic         w_ifid_clr;
    logic [31:0]  w_ifid_instr;

    assign w_stall      = bus.Stall_IF | bus.Stall_ID;
    assign w_redirect   = (bus.PCSrc_ID | bus.Jump_ID) & ~w_stall;
    assign w_target     = word_align(bus.Jump_ID ? bus.PCJump_ID : bus.PCBranch_ID);
    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_ifid_instr = (r_state == HOLD) ? r_hold : bus.imem_rdata;

    assign bus.imem_req  = (r_state != HOLD);
    assign bus.imem_addr = r_req_addr;

    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_req_addr_nx = r_req_addr;
        w_hold_nx     = r_hold;
        w_ifid_clr    = 1'b1;
        case (r_state)
            REQ: begin
                if (w_redirect) begin
                    w_pc_nx = w_target;
                    if (bus.imem_ready)
                        w_req_addr_nx = w_target;
                    else
                        w_state_nx = DROP;
                end else if (bus.imem_ready) begin
                    if (w_stall) begin
                        w_hold_nx  = bus.imem_rdata;
                        w_state_nx = HOLD;
                    end else begin
                        w_ifid_clr    = 1'b0;
                        w_pc_nx       = w_pc_plus4;
                        w_req_addr_nx = w_pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (w_redirect) begin
                    w_pc_nx       = w_target;
                    w_req_addr_nx = w_target;
                    w_state_nx    = REQ;
                end else if (!w_stall) begin
                    w_ifid_clr    = 1'b0;
                    w_pc_nx       = w_pc_plus4;
                    w_req_addr_nx = w_pc_plus4;
                    w_state_nx    = REQ;
                end
            end
            DROP: begin
                // The in-flight response belongs to the old path; only track the new PC.
                if (w_redirect)
                    w_pc_nx = w_target;
                if (bus.imem_ready) begin
                    w_req_addr_nx = w_pc_nx;
                    w_state_nx    = REQ;
                end
            end
            default: w_state_nx = REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_hold     <= NOP_INSTR;
        end else begin
            r_state    <= w_state_nx;
            r_pc       <= w_pc_nx;
            r_req_addr <= w_req_addr_nx;
            r_hold     <= w_hold_nx;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (~w_stall),
        .i_clr     (w_ifid_clr),
        .i_instr   (w_ifid_instr),
        .i_pcplus4 (w_pc_plus4),
        .o_instr   (bus.Instr_ID),
        .o_pcplus4 (bus.PCPlus4_ID),
        .o_valid   (bus.Valid_ID)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a transaction-level model.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_if bus();

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit follow;

    logic [31:0] m_pc, m_addr, m_instr, m_pc4;
    logic        m_valid, m_stale;
    logic [31:0] held[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: a PC, the address on the bus, a "stale" flag for an abandoned
    // request, a one-entry queue for a word caught during a stall, and IF/ID.
    task automatic model_step();
        logic        stall, redir;
        logic [31:0] tgt, w;
        if (!rst_n) begin
            m_pc = RST_PC; m_addr = RST_PC; m_stale = 1'b0; held.delete();
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else begin
            stall = bus.Stall_IF | bus.Stall_ID;
            redir = (bus.PCSrc_ID | bus.Jump_ID) & ~stall;
            tgt   = (bus.Jump_ID ? bus.PCJump_ID : bus.PCBranch_ID) & 32'hFFFF_FFFC;
            if (redir) begin
                m_instr = 32'h0; m_valid = 1'b0;
                m_pc = tgt;
                if (held.size() == 0 && !bus.imem_ready)
                    m_stale = 1'b1;
                else begin
                    m_addr = tgt; m_stale = 1'b0;
                end
                held.delete();
            end else if (m_stale) begin
                if (!stall) begin m_instr = 32'h0; m_valid = 1'b0; end
                if (bus.imem_ready) begin m_stale = 1'b0; m_addr = m_pc; end
            end else if (held.size() != 0 || bus.imem_ready) begin
                w = (held.size() != 0) ? held[0] : bus.imem_rdata;
                if (stall) begin
                    if (held.size() == 0) held.push_back(bus.imem_rdata);
                end else begin
                    m_instr = w; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
                    held.delete();
                    m_pc = m_pc + 32'd4;
                    m_addr = m_pc;
                end
            end else if (!stall) begin
                m_instr = 32'h0; m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        if (follow) bus.imem_rdata = bus.imem_addr;
        @(posedge clk);
        model_step();
        #1;
        chk("Valid_ID", {31'b0, bus.Valid_ID}, {31'b0, m_valid});
        chk("Instr_ID", bus.Instr_ID, m_instr);
        chk("PCPlus4_ID", bus.PCPlus4_ID, m_pc4);
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, held.size() == 0});
        if (held.size() == 0) chk("imem_addr", bus.imem_addr, m_addr);
    endtask

    initial begin
        follow = 1'b1;
        rst_n = 1'b0;
        bus.Stall_IF = 0; bus.Stall_ID = 0; bus.PCSrc_ID = 0; bus.Jump_ID = 0;
        bus.PCBranch_ID = 0; bus.PCJump_ID = 0; bus.imem_ready = 1; bus.imem_rdata = 0;
        tick();
        tick();
        chk("reset_valid", {31'b0, bus.Valid_ID}, 32'd0);
        chk("reset_addr", bus.imem_addr, RST_PC);
        // Streaming fetch with rdata = addr
        rst_n = 1'b1;
        tick();
        chk("first_pc4", bus.PCPlus4_ID, 32'd4);
        chk("first_valid", {31'b0, bus.Valid_ID}, 32'd1);
        tick(); tick(); tick();
        chk("stream_pc4", bus.PCPlus4_ID, 32'd16);
        chk("addr_at_10", bus.imem_addr, 32'h10);
        // Stall across a response at 0x10
        bus.Stall_IF = 1;
        tick();
        chk("hold_req", {31'b0, bus.imem_req}, 32'd0);
        bus.imem_ready = 0;
        tick(); tick();
        chk("hold_req_late", {31'b0, bus.imem_req}, 32'd0);
        bus.Stall_IF = 0;
        tick();
        chk("hold_instr", bus.Instr_ID, 32'h10);
        chk("hold_next_addr", bus.imem_addr, 32'h14);
        // Branch while the request is pending
        bus.PCSrc_ID = 1; bus.PCBranch_ID = 32'h103;
        tick();
        chk("drop_old_addr", bus.imem_addr, 32'h14);
        chk("drop_bubble", {31'b0, bus.Valid_ID}, 32'd0);
        bus.PCSrc_ID = 0; bus.imem_ready = 1;
        tick();
        chk("drop_new_addr", bus.imem_addr, 32'h100);
        chk("drop_no_wrong_path", {31'b0, bus.Valid_ID}, 32'd0);
        tick();
        chk("target_instr", bus.Instr_ID, 32'h100);
        // Branch under stall is ignored
        bus.imem_ready = 0; bus.PCSrc_ID = 1; bus.PCBranch_ID = 32'h200; bus.Stall_ID = 1;
        tick();
        chk("stalled_branch_addr", bus.imem_addr, 32'h104);
        bus.Stall_ID = 0;
        // Jump wins over branch
        bus.imem_ready = 1; bus.PCBranch_ID = 32'h300; bus.Jump_ID = 1; bus.PCJump_ID = 32'h402;
        tick();
        chk("jump_priority", bus.imem_addr, 32'h400);
        // Wrap at the top of the address space
        bus.PCSrc_ID = 0; bus.PCJump_ID = 32'hFFFF_FFFE;
        tick();
        chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        bus.Jump_ID = 0;
        tick();
        chk("wrap_addr", bus.imem_addr, 32'h0);
        chk("wrap_pc4", bus.PCPlus4_ID, 32'h0);
        // Reset while dropping a response
        tick();
        bus.imem_ready = 0; bus.PCSrc_ID = 1; bus.PCBranch_ID = 32'h800;
        tick();
        chk("pre_reset_addr", bus.imem_addr, 32'h4);
        bus.PCSrc_ID = 0; rst_n = 0; bus.imem_ready = 1;
        tick();
        rst_n = 1; bus.imem_ready = 0;
        tick();
        chk("post_reset_addr", bus.imem_addr, RST_PC);
        chk("post_reset_valid", {31'b0, bus.Valid_ID}, 32'd0);
        // Randomized traffic
        follow = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.Stall_IF    = ($urandom_range(0, 9) == 0);
            bus.Stall_ID    = ($urandom_range(0, 9) == 0);
            bus.PCSrc_ID    = ($urandom_range(0, 6) == 0);
            bus.Jump_ID     = ($urandom_range(0, 9) == 0);
            bus.PCBranch_ID = $urandom;
            bus.PCJump_ID   = $urandom;
            bus.imem_ready  = ($urandom_range(0, 1) == 1);
            bus.imem_rdata  = $urandom;
            rst_n           = ($urandom_range(0, 99) != 0);
            tick();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
